// File: rtl/sdram_bridge_pkg.sv
// Shared definitions for the SDRAM Wishbone arbiter bridge: FSM encoding,
// byte-lane width derivation and the round-robin successor function.
package sdram_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_REPLY = 2'd2
    } state_e;

    function automatic int selw(input int dw);
        return dw / 8;
    endfunction

    function automatic int rr_next(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/sdram_wb_arb_bridge_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr_i,
// wrapping modulo NCH; returns a one-hot grant and its index.
module rr_arbiter #(
    parameter int NCH = 2,
    parameter int IW  = 1
) (
    input  logic [NCH-1:0] req_i,
    input  logic [IW-1:0]  ptr_i,
    output logic [NCH-1:0] gnt_o,
    output logic [IW-1:0]  idx_o
);

    int   pos;
    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < NCH; k++) begin
            pos = int'(ptr_i) + k;
            if (pos >= NCH) pos = pos - NCH;
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/sdram_wb_arb_bridge.sv
// Arbitrates NCH Wishbone masters onto the single request/ack port of sdram_top,
// and generates the delayed controller reset. Optional watchdog: SDRAM_TIMEOUT_EN.
module sdram_wb_arb_bridge
    import sdram_bridge_pkg::*;
#(
    parameter  int NCH     = 2,
    parameter  int AW      = 21,
    parameter  int DW      = 16,
    parameter  int RST_DLY = 3,
    parameter  int TIMEOUT = 255,
    localparam int SELW    = selw(DW)
) (
    input  logic              clk_p,
    input  logic              rst_n,
    input  logic              sys_reset,
    input  logic [NCH-1:0]    wb_stb,
    input  logic [NCH-1:0]    wb_we,
    input  logic [NCH*SELW-1:0] wb_sel,
    input  logic [NCH*AW-1:0] wb_adr,
    input  logic [NCH*DW-1:0] wb_dat_i,
    output logic [NCH-1:0]    wb_ack,
    output logic [DW-1:0]     wb_dat_o,
    output logic              ctl_rst_n,
    input  logic              ctl_init_done,
    output logic              ctl_wr_req,
    output logic              ctl_rd_req,
    input  logic              ctl_wr_ack,
    input  logic              ctl_rd_ack,
    input  logic [DW-1:0]     ctl_rdata,
    output logic [AW:0]       ctl_addr,
    output logic [DW-1:0]     ctl_wdata,
    output logic [SELW-1:0]   ctl_be,
    output logic [SELW-1:0]   dqm,
    output logic              ready,
    output logic              to_err
);

    localparam int IW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DLYW = $clog2(RST_DLY + 1) + 1;
    localparam logic [DLYW-1:0] DLY_MAX = DLYW'(RST_DLY);

    logic [1:0]      rsync_q;
    logic            srst;
    logic [DLYW-1:0] dly_q;
    logic            crst_n_q;

    // Synchronised reset request, held asserted until the first edges after rst_n release.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) rsync_q <= 2'b11;
        else        rsync_q <= {rsync_q[0], sys_reset};
    end
    assign srst = rsync_q[1];

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            dly_q    <= '0;
            crst_n_q <= 1'b0;
        end else if (srst) begin
            dly_q    <= '0;
            crst_n_q <= 1'b0;
        end else if (dly_q != DLY_MAX) begin
            dly_q    <= dly_q + 1'b1;
            crst_n_q <= (dly_q + 1'b1 == DLY_MAX);
        end else begin
            crst_n_q <= 1'b1;
        end
    end

    assign ctl_rst_n = crst_n_q;
    assign ready     = ctl_init_done & crst_n_q;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d, gidx_q, gidx_d;
    logic            we_q, we_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   wdat_q, wdat_d, rdat_q, rdat_d;
    logic [SELW-1:0] sel_q, sel_d, dqm_q, dqm_d;
    logic [NCH-1:0]  arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            ctl_ack;

    rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
        .req_i (wb_stb),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    assign ctl_ack = we_q ? ctl_wr_ack : ctl_rd_ack;

`ifdef SDRAM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          to_err_q, to_err_d;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        dqm_d   = dqm_q;
        rdat_d  = rdat_q;
`ifdef SDRAM_TIMEOUT_EN
        to_cnt_d = '0;
        to_err_d = to_err_q;
`endif
        if (srst) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ready && (|arb_gnt)) begin
                        gidx_d  = arb_idx;
                        we_d    = wb_we[arb_idx];
                        adr_d   = wb_adr[int'(arb_idx)*AW +: AW];
                        wdat_d  = wb_dat_i[int'(arb_idx)*DW +: DW];
                        sel_d   = wb_sel[int'(arb_idx)*SELW +: SELW];
                        dqm_d   = wb_we[arb_idx] ? ~wb_sel[int'(arb_idx)*SELW +: SELW] : '0;
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ctl_ack) begin
                        if (!we_q) rdat_d = ctl_rdata;
                        state_d = ST_REPLY;
                    end
`ifdef SDRAM_TIMEOUT_EN
                    else if (to_cnt_q == TO_LAST) begin
                        rdat_d   = '1;
                        to_err_d = 1'b1;
                        state_d  = ST_REPLY;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
`endif
                end
                ST_REPLY: begin
                    // Exit only once the master has dropped stb, so a held stb gets one transfer.
                    if (!wb_stb[gidx_q]) begin
                        state_d = ST_IDLE;
                        ptr_d   = IW'(rr_next(int'(gidx_q), NCH));
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            dqm_q   <= '0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            dqm_q   <= dqm_d;
            rdat_q  <= rdat_d;
        end
    end

`ifdef SDRAM_TIMEOUT_EN
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_err_q <= to_err_d;
        end
    end
    assign to_err = to_err_q;
`else
    // Watchdog absent: flag is constant low for any legal TIMEOUT.
    assign to_err = (TIMEOUT < 0);
`endif

    always_comb begin
        wb_ack = '0;
        if (state_q == ST_REPLY && !srst) wb_ack[gidx_q] = wb_stb[gidx_q];
    end

    assign ctl_wr_req = (state_q == ST_REQ) & we_q & ~srst;
    assign ctl_rd_req = (state_q == ST_REQ) & ~we_q & ~srst;
    assign ctl_addr   = {1'b0, adr_q};
    assign ctl_wdata  = wdat_q;
    assign ctl_be     = sel_q;
    assign dqm        = dqm_q;
    assign wb_dat_o   = rdat_q;

endmodule
